lvds_tx_gearbox: RTL and testbench

LVDS_TX_GEARBOX -- requirements
Module: lvds_tx_gearbox

---
 rtl/lvds_tx_pkg.sv | 24 ++
 rtl/lvds_tx_gearbox_lane.sv | 48 ++++
 rtl/lvds_tx_gearbox.sv | 166 ++++++++++++++++
 tb/tb_lvds_tx_gearbox.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/lvds_tx_pkg.sv
// Shared types and default line patterns for the LVDS transmit gearbox.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lvds_tx_pkg;

    // Link state as seen on O_state.
    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_TRAIN     = 2'd1,
        ST_DATA      = 2'd2
    } tx_state_e;

    // Per-cycle command from the shared controller to every lane.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,  // drive idle and refill the holding word with idle
        OP_TRAIN = 2'd1,  // drive the training slice
        OP_LOAD  = 2'd2,  // capture a new word, drive its slice 0
        OP_NEXT  = 2'd3   // drive the selected slice of the held word
    } lane_op_e;

    localparam logic [9:0] DEF_IDLE_PAT  = 10'h155;
    localparam logic [9:0] DEF_TRAIN_PAT = 10'h3E0;

endpackage

// File: rtl/lvds_tx_gearbox_lane.sv
// One lane: holds a W-bit word and emits one registered slice per cycle.
// Latency: 1 cycle from controller command to O_tx.
// Backpressure: none; the shared controller decides when a word is loaded.
module lvds_tx_gearbox_lane
    import lvds_tx_pkg::*;
#(
    parameter int                 SLICE_W   = 10,
    parameter int                 RATIO     = 4,
    parameter int                 PW        = 2,
    parameter logic [SLICE_W-1:0] IDLE_PAT  = DEF_IDLE_PAT,
    parameter logic [SLICE_W-1:0] TRAIN_PAT = DEF_TRAIN_PAT
) (
    input  logic                       I_clk,
    input  logic                       I_rst,
    input  lane_op_e                   I_op,
    input  logic [PW-1:0]              I_slice,
    input  logic [SLICE_W*RATIO-1:0]   I_word,
    output logic [SLICE_W-1:0]         O_tx
);

    logic [SLICE_W*RATIO-1:0] r_word;
    logic [SLICE_W-1:0]       r_tx;

    // Holding register and registered slice mux; idle refill makes an
    // underflowed or discarded slot play out as idle slices.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_word <= '0;
            r_tx   <= '0;
        end else begin
            case (I_op)
                OP_IDLE: begin
                    r_word <= {RATIO{IDLE_PAT}};
                    r_tx   <= IDLE_PAT;
                end
                OP_TRAIN: r_tx <= TRAIN_PAT;
                OP_LOAD: begin
                    r_word <= I_word;
                    r_tx   <= I_word[SLICE_W-1:0];
                end
                default: r_tx <= r_word[I_slice*SLICE_W +: SLICE_W];
            endcase
        end
    end

    assign O_tx = r_tx;

endmodule

// File: rtl/lvds_tx_gearbox.sv
// Lock/train/data sequencer feeding NCH lanes of RATIO:1 word-to-slice gearing.
// Latency: accepted word's slice 0 on O_tx_in 1 cycle after acceptance.
// Backpressure: O_ready high only on the last phase of a word slot; missed slots play idle.
module lvds_tx_gearbox
    import lvds_tx_pkg::*;
#(
    parameter int                 NCH       = 20,
    parameter int                 SLICE_W   = 10,
    parameter int                 RATIO     = 4,
    parameter int                 LOCK_DLY  = 16,
    parameter int                 TRAIN_LEN = 64,
    parameter logic [SLICE_W-1:0] IDLE_PAT  = DEF_IDLE_PAT,
    parameter logic [SLICE_W-1:0] TRAIN_PAT = DEF_TRAIN_PAT
) (
    input  logic                       I_clk,
    input  logic                       I_rst,
    input  logic                       I_tx_locked,
    input  logic                       I_retrain,
    input  logic [NCH*SLICE_W*RATIO-1:0] I_data,
    input  logic                       I_valid,
    output logic                       O_ready,
    output logic [NCH*SLICE_W-1:0]     O_tx_in,
    output logic [1:0]                 O_state,
    output logic                       O_train_done,
    output logic                       O_underflow,
    output logic [15:0]                O_underflow_cnt
);

    localparam int W   = SLICE_W * RATIO;
    localparam int PW  = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int LCW = $clog2(LOCK_DLY + 1);

    tx_state_e        r_state;
    logic [PW-1:0]    r_p;
    logic [LCW-1:0]   r_lock_cnt;
    logic [15:0]      r_train_cnt;
    logic             r_retrain_pend;
    logic             r_train_done;
    logic             r_underflow;
    logic [15:0]      r_uf_cnt;

    logic             w_slot;
    logic             w_lock_done;
    logic             w_train_last;
    logic [PW-1:0]    w_p_next;
    lane_op_e         w_op;

    assign w_slot       = (r_state == ST_DATA) && (r_p == PW'(RATIO - 1));
    assign w_lock_done  = (r_lock_cnt == LCW'(LOCK_DLY));
    assign w_train_last = (r_train_cnt == 16'(TRAIN_LEN - 1));
    assign w_p_next     = r_p + PW'(1);

    // A retrain latched mid-word also blocks acceptance: that slot goes to TRAIN.
    assign O_ready = w_slot & I_tx_locked & ~I_retrain & ~r_retrain_pend;

    // Lane command for the coming edge, mirroring the sequencer's decisions below.
    always_comb begin
        w_op = OP_IDLE;
        if (I_tx_locked) begin
            case (r_state)
                ST_WAIT_LOCK: if (w_lock_done) w_op = OP_TRAIN;
                ST_TRAIN:     if (!w_train_last) w_op = OP_TRAIN;
                ST_DATA: begin
                    if (!w_slot)                          w_op = OP_NEXT;
                    else if (I_retrain || r_retrain_pend) w_op = OP_TRAIN;
                    else if (I_valid)                     w_op = OP_LOAD;
                    else                                  w_op = OP_IDLE;
                end
                default: w_op = OP_IDLE;
            endcase
        end
    end

    // Sequencer: lock qualification, training count, data phase and status pulses.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_state        <= ST_WAIT_LOCK;
            r_p            <= '0;
            r_lock_cnt     <= '0;
            r_train_cnt    <= '0;
            r_retrain_pend <= 1'b0;
            r_train_done   <= 1'b0;
            r_underflow    <= 1'b0;
            r_uf_cnt       <= '0;
        end else begin
            r_train_done <= 1'b0;
            r_underflow  <= 1'b0;
            if (!I_tx_locked) begin
                r_state        <= ST_WAIT_LOCK;
                r_p            <= '0;
                r_lock_cnt     <= '0;
                r_train_cnt    <= '0;
                r_retrain_pend <= 1'b0;
            end else begin
                case (r_state)
                    ST_WAIT_LOCK: begin
                        if (w_lock_done) begin
                            r_state     <= ST_TRAIN;
                            r_lock_cnt  <= '0;
                            r_train_cnt <= '0;
                        end else begin
                            r_lock_cnt <= r_lock_cnt + LCW'(1);
                        end
                    end
                    ST_TRAIN: begin
                        if (w_train_last) begin
                            r_state      <= ST_DATA;
                            r_p          <= PW'(RATIO - 1);
                            r_train_done <= 1'b1;
                            r_train_cnt  <= '0;
                        end else begin
                            r_train_cnt <= r_train_cnt + 16'd1;
                        end
                    end
                    ST_DATA: begin
                        if (w_slot) begin
                            if (I_retrain || r_retrain_pend) begin
                                r_state        <= ST_TRAIN;
                                r_retrain_pend <= 1'b0;
                                r_train_cnt    <= '0;
                            end else begin
                                r_p <= '0;
                                if (!I_valid) begin
                                    r_underflow <= 1'b1;
                                    if (r_uf_cnt != 16'hFFFF)
                                        r_uf_cnt <= r_uf_cnt + 16'd1;
                                end
                            end
                        end else begin
                            r_p <= w_p_next;
                            if (I_retrain)
                                r_retrain_pend <= 1'b1;
                        end
                    end
                    default: r_state <= ST_WAIT_LOCK;
                endcase
            end
        end
    end

    assign O_state         = r_state;
    assign O_train_done    = r_train_done;
    assign O_underflow     = r_underflow;
    assign O_underflow_cnt = r_uf_cnt;

    genvar c;
    generate
        for (c = 0; c < NCH; c++) begin : g_lane
            lvds_tx_gearbox_lane #(
                .SLICE_W  (SLICE_W),
                .RATIO    (RATIO),
                .PW       (PW),
                .IDLE_PAT (IDLE_PAT),
                .TRAIN_PAT(TRAIN_PAT)
            ) u_lane (
                .I_clk  (I_clk),
                .I_rst  (I_rst),
                .I_op   (w_op),
                .I_slice(w_p_next),
                .I_word (I_data[c*W +: W]),
                .O_tx   (O_tx_in[c*SLICE_W +: SLICE_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_lvds_tx_gearbox.sv
// Scoreboard bench: a plan-queue model predicts every output cycle of the gearbox.
// Latency: expected item for cycle n+1 is queued when cycle n's inputs are driven.
// Backpressure: O_ready is checked against the model each cycle before the edge.
module tb_lvds_tx_gearbox;

    localparam int NCH = 2;
    localparam int SW  = 10;
    localparam int R   = 4;
    localparam int LD  = 4;
    localparam int TL  = 8;
    localparam int W   = SW * R;
    localparam logic [SW-1:0] IDLE = 10'h155;
    localparam logic [SW-1:0] TRN  = 10'h3E0;

    typedef struct {
        logic [NCH*SW-1:0] tx;
        logic [1:0]        st;
        logic              done;
        logic              uf;
        logic [15:0]       cnt;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst, lock, retrain, valid;
    logic [NCH*W-1:0]  data;
    logic              o_ready;
    logic [NCH*SW-1:0] o_tx;
    logic [1:0]        o_state;
    logic              o_done, o_uf;
    logic [15:0]       o_cnt;

    exp_t        exp_q[$];
    exp_t        plan[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          run = 0;
    bit          pend = 0;
    logic [15:0] ucnt = 16'd0;
    logic [1:0]  cur_st = 2'd0;

    always #5 clk = ~clk;

    lvds_tx_gearbox #(
        .NCH(NCH), .SLICE_W(SW), .RATIO(R), .LOCK_DLY(LD), .TRAIN_LEN(TL),
        .IDLE_PAT(IDLE), .TRAIN_PAT(TRN)
    ) dut (
        .I_clk(clk), .I_rst(rst), .I_tx_locked(lock), .I_retrain(retrain),
        .I_data(data), .I_valid(valid), .O_ready(o_ready), .O_tx_in(o_tx),
        .O_state(o_state), .O_train_done(o_done), .O_underflow(o_uf),
        .O_underflow_cnt(o_cnt)
    );

    function automatic exp_t mk(input logic [SW-1:0] s, input logic [1:0] st,
                                input logic dn, input logic u);
        exp_t e;
        e.tx = {NCH{s}}; e.st = st; e.done = dn; e.uf = u; e.cnt = 16'd0;
        return e;
    endfunction

    // Training burst followed by the single DATA entry cycle (idle, done pulse).
    task automatic push_train();
        for (int i = 0; i < TL; i++) plan.push_back(mk(TRN, 2'd1, 1'b0, 1'b0));
        plan.push_back(mk(IDLE, 2'd2, 1'b1, 1'b0));
    endtask

    task automatic push_word(input logic [NCH*W-1:0] d);
        exp_t e;
        for (int k = 0; k < R; k++) begin
            e = mk(IDLE, 2'd2, 1'b0, 1'b0);
            for (int c = 0; c < NCH; c++) e.tx[c*SW +: SW] = d[c*W + k*SW +: SW];
            plan.push_back(e);
        end
    endtask

    task automatic model_step(input bit chk_rdy);
        exp_t nx;
        bit   er;
        er = (cur_st == 2'd2) && (plan.size() == 0) && lock && !retrain && !pend;
        if (chk_rdy) begin
            n_cmp++;
            if (o_ready !== er) begin
                n_bad++;
                $display("FAIL ready: got %b want %b at %0t", o_ready, er, $time);
            end
        end
        nx = mk(IDLE, 2'd0, 1'b0, 1'b0);
        if (rst) begin
            plan.delete(); run = 0; pend = 0; ucnt = 16'd0; nx.tx = '0;
        end else if (!lock) begin
            plan.delete(); run = 0; pend = 0;
        end else begin
            if (plan.size() == 0) begin
                if (cur_st == 2'd0) begin
                    run++;
                    if (run > LD) begin run = 0; push_train(); end
                end else if (retrain || pend) begin
                    pend = 0; push_train();
                end else if (valid) begin
                    push_word(data);
                end else begin
                    if (ucnt != 16'hFFFF) ucnt++;
                    plan.push_back(mk(IDLE, 2'd2, 1'b0, 1'b1));
                    for (int i = 1; i < R; i++) plan.push_back(mk(IDLE, 2'd2, 1'b0, 1'b0));
                end
            end else if (cur_st == 2'd2 && retrain) begin
                pend = 1;
            end
            if (plan.size() > 0) nx = plan.pop_front();
        end
        nx.cnt = ucnt;
        cur_st = nx.st;
        exp_q.push_back(nx);
    endtask

    // One stimulus cycle: drive at the falling edge, then check O_ready and predict.
    task automatic cyc(input bit r, input bit l, input bit rt, input bit v,
                       input logic [NCH*W-1:0] d, input bit dep);
        @(negedge clk);
        rst = r; lock = l; retrain = rt; valid = v; data = d;
        #1;
        if (dep) begin
            dut.r_uf_cnt = 16'hFFFF;
            ucnt = 16'hFFFF;
        end
        model_step(1'b1);
    endtask

    function automatic logic [NCH*W-1:0] rnd_data();
        return {16'($urandom), 32'($urandom), 32'($urandom)};
    endfunction

    // Monitor: every output cycle is compared with the oldest predicted item.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_empty: no prediction queued at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                if (o_tx !== e.tx || o_state !== e.st || o_done !== e.done ||
                    o_uf !== e.uf || o_cnt !== e.cnt) begin
                    n_bad++;
                    n_cmp = n_cmp;
                    $display("FAIL out@%0t: tx %h/%h st %0d/%0d done %b/%b uf %b/%b cnt %h/%h (got/want)",
                             $time, o_tx, e.tx, o_state, e.st, o_done, e.done,
                             o_uf, e.uf, o_cnt, e.cnt);
                end
            end
        end
    end

    initial begin
        logic [NCH*W-1:0] w0;
        w0 = {rnd_data()};
        w0[W-1:0] = {10'h3FF, 10'h2AA, 10'h155, 10'h0FF};
        rst = 1'b1; lock = 1'b1; retrain = 1'b0; valid = 1'b1; data = w0;
        model_step(1'b0);
        repeat (3) cyc(1, 1, 0, 1, w0, 0);

        // Lock, train, then back-to-back words starting with the known lane-0 word.
        repeat (40) cyc(0, 1, 0, 1, w0, 0);
        // Missed slot, then resume.
        repeat (4)  cyc(0, 1, 0, 0, rnd_data(), 0);
        repeat (12) cyc(0, 1, 0, 1, rnd_data(), 0);
        // Retrain pulse mid-word and a lock drop together with retrain.
        cyc(0, 1, 0, 1, rnd_data(), 0);
        cyc(0, 1, 1, 1, rnd_data(), 0);
        repeat (30) cyc(0, 1, 0, 1, rnd_data(), 0);
        cyc(0, 0, 1, 1, rnd_data(), 0);
        repeat (30) cyc(0, 1, 0, 1, rnd_data(), 0);

        // Randomised traffic, retrains and lock dropouts.
        repeat (2500)
            cyc(0, ($urandom_range(0, 99) != 0), ($urandom_range(0, 59) == 0),
                ($urandom_range(0, 7) != 0), rnd_data(), 0);

        // Counter saturation from a preset all-ones value.
        repeat (40) cyc(0, 1, 0, 1, rnd_data(), 0);
        cyc(0, 1, 0, 1, rnd_data(), 1);
        repeat (8)  cyc(0, 1, 0, 0, rnd_data(), 0);
        repeat (10) cyc(0, 1, 0, 1, rnd_data(), 0);

        // Reset in the middle of a word, then relock.
        repeat (2)  cyc(0, 1, 0, 1, rnd_data(), 0);
        repeat (2)  cyc(1, 1, 0, 0, rnd_data(), 0);
        repeat (30) cyc(0, 1, 0, 1, rnd_data(), 0);

        @(negedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d predictions left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
